// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode front end: instruction field
// layout, the HALT opcode and the sequencer state encoding.
package pipe_pkg;

  localparam int unsigned INSTR_W = 24;

  localparam int unsigned FUNC_HI = 23;
  localparam int unsigned FUNC_LO = 20;
  localparam int unsigned RD_HI   = 19;
  localparam int unsigned RD_LO   = 16;
  localparam int unsigned RS1_HI  = 15;
  localparam int unsigned RS1_LO  = 12;
  localparam int unsigned RS2_HI  = 11;
  localparam int unsigned RS2_LO  = 8;
  localparam int unsigned ADDR_HI = 7;
  localparam int unsigned ADDR_LO = 0;

  localparam logic [3:0] FUNC_HALT = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  // Field order matches the instruction encoding, so a word casts directly.
  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] word);
    instr_t d;
    d.func = word[FUNC_HI:FUNC_LO];
    d.rd   = word[RD_HI:RD_LO];
    d.rs1  = word[RS1_HI:RS1_LO];
    d.rs2  = word[RS2_HI:RS2_LO];
    d.addr = word[ADDR_HI:ADDR_LO];
    return d;
  endfunction

endpackage

// File: rtl/pipe_fetch_decode_hazard.sv
// RAW hazard detector: remembers the destination registers of the last
// HAZ_DIST output-register advances and flags a candidate whose rs1 or rs2
// matches any valid entry. Bubbles shift in invalid entries so a stalled
// dependency ages out.
module pipe_hazard_unit #(
  parameter int unsigned HAZ_DIST = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift,
  input  logic       shift_valid,
  input  logic [3:0] shift_rd,
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  output logic       hazard
);

  logic [HAZ_DIST-1:0]      hist_v;
  logic [HAZ_DIST-1:0][3:0] hist_rd;

  // History shift register, newest entry at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_v  <= '0;
      hist_rd <= '0;
    end else if (shift) begin
      hist_v[0]  <= shift_valid;
      hist_rd[0] <= shift_rd;
      for (int unsigned i = 1; i < HAZ_DIST; i++) begin
        hist_v[i]  <= hist_v[i-1];
        hist_rd[i] <= hist_rd[i-1];
      end
    end
  end

  // Conservative compare: rs2 is checked whatever the function.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < HAZ_DIST; i++) begin
      if (hist_v[i] && ((hist_rd[i] == rs1) || (hist_rd[i] == rs2)))
        hazard = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_fetch_decode.sv
// Instruction fetch/decode front end: loadable imem, program counter,
// field split and valid/ready issue toward the operand-read stage; stops
// at the HALT opcode.
// Optional feature macro: HAZARD_STALL_EN (RAW bubble insertion using the
// last HAZ_DIST issued rd values). Undefined by default.
module pipe_fetch_decode
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W     = 4,
  parameter int unsigned INSTR_W  = pipe_pkg::INSTR_W,
  parameter int unsigned HAZ_DIST = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [3:0]         rd,
  output logic [3:0]         func,
  output logic [7:0]         addr,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic [7:0]         issued_cnt
);

  state_t state, state_nxt;

  logic [INSTR_W-1:0] imem [2**PC_W];

  instr_t cand;
  logic   advance;
  logic   is_halt;
  logic   stall;
  logic   do_issue;
  logic   do_bubble;
  logic   do_halt;

  assign cand      = decode(imem[pc]);
  assign advance   = (state == RUN) && (!out_valid || out_ready);
  assign is_halt   = (cand.func == FUNC_HALT);
  assign do_halt   = advance && is_halt;
  assign do_issue  = advance && !is_halt && !stall;
  assign do_bubble = advance && !is_halt && stall;

`ifdef HAZARD_STALL_EN
  pipe_hazard_unit #(
    .HAZ_DIST (HAZ_DIST)
  ) u_hazard (
    .clk         (clk),
    .rst         (rst),
    .shift       (do_issue || do_bubble),
    .shift_valid (do_issue),
    .shift_rd    (cand.rd),
    .rs1         (cand.rs1),
    .rs2         (cand.rs2),
    .hazard      (stall)
  );
`else
  assign stall = 1'b0;
`endif

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)   state_nxt = RUN;
      RUN:     if (do_halt) state_nxt = HALT;
      HALT:    if (start)   state_nxt = RUN;
      default:              state_nxt = IDLE;
    endcase
  end

  // Instruction memory: loadable only while idle, untouched by reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we)
      imem[prog_addr] <= prog_data;
  end

  // Program counter, output register, halt flag and accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      out_valid  <= 1'b0;
      rs1        <= '0;
      rs2        <= '0;
      rd         <= '0;
      func       <= '0;
      addr       <= '0;
      halted     <= 1'b0;
      issued_cnt <= '0;
    end else begin
      if (out_valid && out_ready)
        issued_cnt <= issued_cnt + 8'd1;
      if (state == IDLE && start) begin
        pc <= '0;
      end else if (state == HALT && start) begin
        pc     <= '0;
        halted <= 1'b0;
      end else if (do_halt) begin
        out_valid <= 1'b0;
        halted    <= 1'b1;
      end else if (do_bubble) begin
        out_valid <= 1'b0;
      end else if (do_issue) begin
        out_valid <= 1'b1;
        rs1       <= cand.rs1;
        rs2       <= cand.rs2;
        rd        <= cand.rd;
        func      <= cand.func;
        addr      <= cand.addr;
        pc        <= pc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_fetch_decode.sv
// Directed bench for pipe_fetch_decode: hand-computed expected fields,
// pc, halt and accept counts across issue, backpressure, wrap, reset,
// hazard spacing and program-while-running cases.
module tb_pipe_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [23:0] prog_data;
  logic        start;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic [3:0]  pc;
  logic        halted;
  logic [7:0]  issued_cnt;
  logic [23:0] fields_obs;

  int tests = 0;
  int fails = 0;

  logic [23:0] exp3 [16];

  pipe_fetch_decode #(
    .PC_W     (4),
    .INSTR_W  (24),
    .HAZ_DIST (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .start      (start),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .func       (func),
    .addr       (addr),
    .pc         (pc),
    .halted     (halted),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  assign fields_obs = {func, rd, rs1, rs2, addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [23:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid",  out_valid, 0);
    check("rst_pc",     pc, 0);
    check("rst_halted", halted, 0);
    check("rst_cnt",    issued_cnt, 0);
    check("rst_fields", fields_obs, 0);

    // Test 1: basic issue then HALT
    load(4'd0, 24'h0A357D);
    load(4'd1, 24'h2C387E);
    load(4'd2, 24'hF00000);
    out_ready = 1'b1;
    do_start();
    check("t1_lat_valid", out_valid, 0);
    tick();
    check("t1_i0_valid",  out_valid, 1);
    check("t1_i0_fields", fields_obs, 24'h0A357D);
    check("t1_i0_pc",     pc, 1);
    tick();
    check("t1_i1_valid",  out_valid, 1);
    check("t1_i1_fields", fields_obs, 24'h2C387E);
    check("t1_i1_cnt",    issued_cnt, 1);
    tick();
    check("t1_h_valid",  out_valid, 0);
    check("t1_h_halted", halted, 1);
    check("t1_h_pc",     pc, 2);
    check("t1_h_cnt",    issued_cnt, 2);
    tick();
    check("t1_h2_valid", out_valid, 0);
    check("t1_h2_pc",    pc, 2);

    // Test 2: backpressure holds outputs
    do_reset();
    out_ready = 1'b0;
    do_start();
    tick();
    check("t2_i0_fields", fields_obs, 24'h0A357D);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_valid",  out_valid, 1);
      check("t2_hold_fields", fields_obs, 24'h0A357D);
      check("t2_hold_pc",     pc, 1);
      check("t2_hold_cnt",    issued_cnt, 0);
    end
    out_ready = 1'b1;
    tick();
    check("t2_i1_fields", fields_obs, 24'h2C387E);
    check("t2_i1_cnt",    issued_cnt, 1);
    tick();
    check("t2_h_halted", halted, 1);
    check("t2_h_cnt",    issued_cnt, 2);

    // Test 3: full memory, pc wrap, 20 accepts
    do_reset();
    for (int k = 0; k < 16; k++) begin
      exp3[k] = {4'(k % 12), 4'(k), 4'(k), 4'(k + 1), 8'(k * 3 + 1)};
      load(4'(k), exp3[k]);
    end
    do_start();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_valid",  out_valid, 1);
      check("t3_fields", fields_obs, exp3[i % 16]);
      check("t3_pc",     pc, (i + 1) % 16);
    end
    tick();
    out_ready = 1'b0;
    check("t3_cnt", issued_cnt, 20);
    check("t3_pc_end", pc, 5);

    // Test 4: reset mid-run
    do_reset();
    do_start();
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("t4_pre_cnt", issued_cnt, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_valid",  out_valid, 0);
    check("t4_pc",     pc, 0);
    check("t4_cnt",    issued_cnt, 0);
    check("t4_halted", halted, 0);
    tick();
    check("t4_idle_valid", out_valid, 0);
    do_start();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_rerun_fields", fields_obs, exp3[i]);
    end

    // Test 5: RAW dependency on the previous rd
    do_reset();
    load(4'd0, 24'h0A357D);
    load(4'd1, 24'h1EA37F);
    load(4'd2, 24'hF00000);
    out_ready = 1'b1;
    do_start();
    tick();
    check("t5_i0_fields", fields_obs, 24'h0A357D);
`ifdef HAZARD_STALL_EN
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t5_bubble_valid", out_valid, 0);
      check("t5_bubble_pc",    pc, 1);
    end
`endif
    tick();
    check("t5_i1_valid",  out_valid, 1);
    check("t5_i1_fields", fields_obs, 24'h1EA37F);
    check("t5_i1_pc",     pc, 2);
    tick();
    check("t5_halted", halted, 1);
    check("t5_cnt",    issued_cnt, 2);

    // Test 6: program with start; prog_we ignored while running
    do_reset();
    load(4'd1, 24'hF00000);
    out_ready = 1'b0;
    start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 24'hD33B7F;
    tick();
    start = 1'b0; prog_we = 1'b0;
    tick();
    check("t6_i0_fields", fields_obs, 24'hD33B7F);
    check("t6_i0_pc",     pc, 1);
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 24'h111111;
    tick();
    prog_we = 1'b0;
    check("t6_hold_fields", fields_obs, 24'hD33B7F);
    out_ready = 1'b1;
    tick();
    check("t6_halted", halted, 1);
    check("t6_h_pc",   pc, 1);
    check("t6_h_valid", out_valid, 0);
    do_reset();
    do_start();
    tick();
    check("t6_rb_fields", fields_obs, 24'hD33B7F);
    tick();
    check("t6_rb_halted", halted, 1);
    check("t6_rb_cnt",    issued_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
